// File: rtl/sierpinski_row_shifter_if.sv
// Row bus from the upstream generator and the serial display-chain pins.
// The producer side holds the master modport; the shifter holds the slave.
interface sierpinski_row_shifter_if;
  logic [7:0] row_in;
  logic       row_valid;
  logic       row_ready;
  logic       sdo;
  logic       sclk;
  logic       slatch;

  modport master (
    output row_in,
    output row_valid,
    input  row_ready,
    input  sdo,
    input  sclk,
    input  slatch
  );

  modport slave (
    input  row_in,
    input  row_valid,
    output row_ready,
    output sdo,
    output sclk,
    output slatch
  );
endinterface

// File: rtl/sierpinski_row_shifter.sv
// Queues generator rows in a small FIFO and shifts each MSB-first onto a 74HC595-style chain.
// Defining SIERPINSKI_ROW_XOR_EN XORs every popped row with the previously loaded word.
//
// state | meaning
// IDLE  | waiting for a queued row, sclk/slatch low
// LOAD  | pop head row into the shift register, present bit 7
// SHIFT | clock out 8 bits, CLKDIV cycles low then CLKDIV cycles high per bit
// LATCH | slatch high for CLKDIV cycles
module sierpinski_row_shifter #(
  parameter int DEPTH  = 4,
  parameter int CLKDIV = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  sierpinski_row_shifter_if.slave bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [DW-1:0] DIV_ONE  = 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          sdo_q, sdo_d;
  logic          sclk_q, sclk_d;
  logic          slatch_q, slatch_d;
  logic          pop;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, div_last;
  logic [7:0]    load_word;

  assign full          = (count == CNT_FULL);
  assign empty         = (count == '0);
  assign push          = ena & bus.row_valid & ~full;
  assign bus.row_ready = ena & ~full;
  assign bus.sdo       = sdo_q;
  assign bus.sclk      = sclk_q;
  assign bus.slatch    = slatch_q;
  assign busy          = (state_q != IDLE);
  assign fifo_count    = count;
  assign div_last      = (div_q == DIV_LAST);

`ifdef SIERPINSKI_ROW_XOR_EN
  logic [7:0] prev_word;
  assign load_word = mem[rd_ptr] ^ prev_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          prev_word <= '0;
    else if (ena && (state_q == LOAD))   prev_word <= load_word;
  end
`else
  assign load_word = mem[rd_ptr];
`endif

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sdo_d    = sdo_q;
    sclk_d   = sclk_q;
    slatch_d = slatch_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d   = 1'b0;
        slatch_d = 1'b0;
        if (!empty) state_d = LOAD;
      end
      LOAD: begin
        pop      = 1'b1;
        shreg_d  = load_word;
        sdo_d    = load_word[7];
        div_d    = '0;
        bit_d    = '0;
        sclk_d   = 1'b0;
        slatch_d = 1'b0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (!div_last) begin
          div_d = div_q + DIV_ONE;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd7) begin
              slatch_d = 1'b1;
              state_d  = LATCH;
            end else begin
              // next bit goes out on the same edge sclk falls
              bit_d   = bit_q + 3'd1;
              sdo_d   = shreg_q[6];
              shreg_d = {shreg_q[6:0], 1'b0};
            end
          end
        end
      end
      LATCH: begin
        if (!div_last) begin
          div_d = div_q + DIV_ONE;
        end else begin
          div_d    = '0;
          slatch_d = 1'b0;
          state_d  = empty ? IDLE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sdo_q    <= 1'b0;
      sclk_q   <= 1'b0;
      slatch_q <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sdo_q    <= sdo_d;
      sclk_q   <= sclk_d;
      slatch_q <= slatch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.row_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (ena) begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (bus.row_valid && full) overflow <= 1'b1;
    end
  end

endmodule
